// File: rtl/avalon_pkg.sv
// Shared types and response codes for the Avalon-MM burst slave.
package avalon_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RD,
      RD_DRAIN,
      WR,
      WR_RESP
   } state_e;

   localparam logic [1:0] RESP_OKAY      = 2'b00;
   localparam logic [1:0] RESP_DECODEERR = 2'b11;

   function automatic logic [1:0] resp_of(input logic err);
      return err ? RESP_DECODEERR : RESP_OKAY;
   endfunction

endpackage

// File: rtl/flex_counter.sv
// Generic up-counter with synchronous clear and programmable rollover.
// Clear and enable in the same cycle restart the count at 1.
module flex_counter #(
   parameter int unsigned NUM_CNT_BITS = 4
) (
   input  logic                    clk,
   input  logic                    n_rst,
   input  logic                    clear,
   input  logic                    count_enable,
   input  logic [NUM_CNT_BITS-1:0] rollover_val,
   output logic [NUM_CNT_BITS-1:0] count_out,
   output logic                    rollover_flag
);

   localparam logic [NUM_CNT_BITS-1:0] CNT_ONE = NUM_CNT_BITS'(1);

   logic [NUM_CNT_BITS-1:0] count_q;
   logic [NUM_CNT_BITS-1:0] count_d;
   logic [NUM_CNT_BITS-1:0] count_base;

   always_comb begin
      count_base = clear ? '0 : count_q;
      count_d    = count_base;
      if (count_enable) begin
         count_d = (count_base == rollover_val) ? CNT_ONE : count_base + CNT_ONE;
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_out     = count_q;
   assign rollover_flag = (count_q == rollover_val);

endmodule

// File: rtl/avalon_burst_slave.sv
// Avalon-MM slave: single/burst reads with pipelined beats, single/burst
// writes with one response per transaction, range-checked against MAX_ADDR.
module avalon_burst_slave
   import avalon_pkg::*;
#(
   parameter int unsigned ADDR_W   = 13,
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned BURST_W  = 10,
   parameter int unsigned MAX_ADDR = 4128
) (
   input  logic               clk,
   input  logic               n_rst,
   input  logic               read,
   input  logic               write,
   input  logic               beginbursttransfer,
   input  logic [BURST_W-1:0] burstcount,
   input  logic [ADDR_W-1:0]  address,
   input  logic [DATA_W-1:0]  writedata,
   input  logic [DATA_W-1:0]  mem_rdata,
   output logic               waitrequest,
   output logic [DATA_W-1:0]  readdata,
   output logic               readdatavalid,
   output logic               writeresponsevalid,
   output logic [1:0]         response,
   output logic [ADDR_W-1:0]  mem_addr,
   output logic [DATA_W-1:0]  mem_wdata,
   output logic               r_ena,
   output logic               w_ena
);

   localparam int unsigned CNT_W = BURST_W + 1;
   localparam int unsigned SUM_W = ADDR_W + BURST_W + 1;

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [SUM_W-1:0] SUM_ONE = SUM_W'(1);
   localparam logic [SUM_W-1:0] MAX_EXT = SUM_W'(MAX_ADDR);

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   base_q, base_d;
   logic [CNT_W-1:0]    len_q, len_d;
   logic                err_q, err_d;

   logic [DATA_W-1:0]   readdata_q, readdata_d;
   logic                rdv_q, rdv_d;
   logic                wrv_q, wrv_d;
   logic [1:0]          response_q, response_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
   logic                r_ena_q, r_ena_d;
   logic                w_ena_q, w_ena_d;

   logic                cnt_clear;
   logic                cnt_en;
   logic [CNT_W-1:0]    cnt;
   logic                cnt_last;

   logic                zero_burst;
   logic [CNT_W-1:0]    cmd_len;
   logic [SUM_W-1:0]    cmd_last_addr;
   logic                cmd_err;
   logic [ADDR_W-1:0]   beat_addr;
   logic                wr_last;

   // cnt holds the number of beats already issued/accepted in the transaction
   flex_counter #(
      .NUM_CNT_BITS(CNT_W)
   ) u_beat_cnt (
      .clk          (clk),
      .n_rst        (n_rst),
      .clear        (cnt_clear),
      .count_enable (cnt_en),
      .rollover_val (len_q),
      .count_out    (cnt),
      .rollover_flag(cnt_last)
   );

   always_comb begin
      zero_burst    = beginbursttransfer && (burstcount == '0);
      cmd_len       = (beginbursttransfer && !zero_burst) ? {1'b0, burstcount} : CNT_ONE;
      cmd_last_addr = SUM_W'(address) + SUM_W'(cmd_len) - SUM_ONE;
      cmd_err       = zero_burst || (cmd_last_addr > MAX_EXT);
      beat_addr     = base_q + ADDR_W'(cnt);
      wr_last       = (cnt == (len_q - CNT_ONE));
   end

   always_comb begin
      state_d     = state_q;
      base_d      = base_q;
      len_d       = len_q;
      err_d       = err_q;
      cnt_clear   = 1'b0;
      cnt_en      = 1'b0;
      readdata_d  = readdata_q;
      rdv_d       = 1'b0;
      wrv_d       = 1'b0;
      response_d  = RESP_OKAY;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      r_ena_d     = 1'b0;
      w_ena_d     = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (read || write) begin
               base_d     = address;
               len_d      = cmd_len;
               err_d      = cmd_err;
               cnt_clear  = 1'b1;
               cnt_en     = 1'b1;
               mem_addr_d = address;
            end
            // Beat 0 is launched straight from the accept edge
            if (read) begin
               state_d = RD;
               r_ena_d = !cmd_err;
            end else if (write) begin
               w_ena_d     = !cmd_err;
               mem_wdata_d = writedata;
               if (cmd_len == CNT_ONE) begin
                  state_d    = WR_RESP;
                  wrv_d      = 1'b1;
                  response_d = resp_of(cmd_err);
               end else begin
                  state_d = WR;
               end
            end
         end
         RD: begin
            rdv_d      = 1'b1;
            readdata_d = err_q ? '0 : mem_rdata;
            response_d = resp_of(err_q);
            if (cnt_last) begin
               state_d = RD_DRAIN;
            end else begin
               cnt_en     = 1'b1;
               r_ena_d    = !err_q;
               mem_addr_d = beat_addr;
            end
         end
         RD_DRAIN: begin
            state_d = IDLE;
         end
         WR: begin
            if (write) begin
               cnt_en      = 1'b1;
               w_ena_d     = !err_q;
               mem_addr_d  = beat_addr;
               mem_wdata_d = writedata;
               if (wr_last) begin
                  state_d    = WR_RESP;
                  wrv_d      = 1'b1;
                  response_d = resp_of(err_q);
               end
            end
         end
         WR_RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q     <= IDLE;
         base_q      <= '0;
         len_q       <= '0;
         err_q       <= 1'b0;
         readdata_q  <= '0;
         rdv_q       <= 1'b0;
         wrv_q       <= 1'b0;
         response_q  <= RESP_OKAY;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         r_ena_q     <= 1'b0;
         w_ena_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         base_q      <= base_d;
         len_q       <= len_d;
         err_q       <= err_d;
         readdata_q  <= readdata_d;
         rdv_q       <= rdv_d;
         wrv_q       <= wrv_d;
         response_q  <= response_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         r_ena_q     <= r_ena_d;
         w_ena_q     <= w_ena_d;
      end
   end

   always_comb begin
      waitrequest = (state_q == RD) || (state_q == RD_DRAIN) || (state_q == WR_RESP);
   end

   assign readdata           = readdata_q;
   assign readdatavalid      = rdv_q;
   assign writeresponsevalid = wrv_q;
   assign response           = response_q;
   assign mem_addr           = mem_addr_q;
   assign mem_wdata          = mem_wdata_q;
   assign r_ena              = r_ena_q;
   assign w_ena              = w_ena_q;

endmodule
